zs_compactor: RTL and testbench

- Zero-skip compactor sitting directly upstream of the output slice register in the zero-skip datapath.
- Accepts one N-lane vector per handshake.
- Emits only the non-zero lanes, one beat per cycle, each tagged with its lane index and an end-of-vector flag.
- Its output handshake is the standard vld/rdy pair, so a single-entry slice register can consume it directly.

---
 rtl/zs_pkg.sv | 32 +++
 rtl/zs_prio_enc.sv | 25 ++
 rtl/zs_compactor.sv | 161 ++++++++++++++++
 tb/tb_zs_compactor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/zs_pkg.sv
// Shared definitions for the zero-skip datapath: default geometry, the beat
// record passed to the downstream slice, the compactor FSM state and a
// popcount helper.
package zs_pkg;

  localparam int unsigned ZsN  = 8;
  localparam int unsigned ZsDw = 8;
  localparam int unsigned ZsIw = $clog2(ZsN);

  typedef struct packed {
    logic [ZsDw-1:0] val;
    logic [ZsIw-1:0] idx;
    logic            last;
    logic            nz;
  } zs_beat_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } zs_state_e;

  // Population count of up to 64 mask bits; callers zero-extend narrower masks.
  function automatic int unsigned zs_popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/zs_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot of that bit, and any-set.
module zs_prio_enc #(
  parameter int unsigned N = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o,
  output logic          any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o    = IW'(i);
        onehot_o = N'(1) << i;
      end
    end
    any_o = |mask_i;
  end

endmodule

// File: rtl/zs_compactor.sv
// Zero-skip compactor: takes one N-lane vector per handshake and emits its
// non-zero lanes one beat per cycle, tagged with lane index and last flag.
// An all-zero vector produces a single marker beat with nz_o=0.
// Optional: define ZS_COMPACTOR_STATS_EN to add zskip_cnt_o, a saturating
// count of skipped zero lanes.
module zs_compactor
  import zs_pkg::*;
#(
  parameter int unsigned N  = ZsN,
  parameter int unsigned DW = ZsDw,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [N*DW-1:0] vec_i,
  input  logic          vld_i,
  output logic          rdy_o,
  output logic [DW-1:0] val_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o,
  output logic          nz_o,
  output logic          vld_o,
`ifdef ZS_COMPACTOR_STATS_EN
  output logic [31:0]   zskip_cnt_o,
`endif
  input  logic          rdy_i
);

  zs_state_e       state_q, state_d;
  logic [N*DW-1:0] vec_q, vec_d;
  logic [N-1:0]    mask_q, mask_d;
  logic            zflag_q, zflag_d;

  logic [N-1:0]    mask_in;
  logic [IW-1:0]   enc_idx;
  logic [N-1:0]    enc_onehot;
  logic            enc_any;
  logic            busy;
  logic            in_acc;
  logic            beat_acc;

  zs_prio_enc #(
    .N(N)
  ) u_prio_enc (
    .mask_i  (mask_q),
    .idx_o   (enc_idx),
    .onehot_o(enc_onehot),
    .any_o   (enc_any)
  );

  // Per-lane non-zero mask of the incoming vector.
  always_comb begin
    mask_in = '0;
    for (int k = 0; k < N; k++) begin
      mask_in[k] = |vec_i[k*DW +: DW];
    end
  end

  assign busy     = (state_q == StBusy);
  // clear_i vetoes both handshakes in its cycle.
  assign in_acc   = vld_i & rdy_o & ~clear_i;
  assign beat_acc = vld_o & rdy_i & ~clear_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a new vector taken with the last beat keeps us in BUSY.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (vld_i) state_d = StBusy;
        StBusy: if (beat_acc && last_o) state_d = vld_i ? StBusy : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs; everything is driven from registers except rdy_o via rdy_i.
  always_comb begin
    vld_o  = busy;
    idx_o  = busy ? enc_idx : '0;
    val_o  = busy ? vec_q[enc_idx*DW +: DW] : '0;
    // Last when no bits remain beyond the current one (or zero-vector marker).
    last_o = busy & (~enc_any | ((mask_q & ~enc_onehot) == '0));
    nz_o   = busy & ~zflag_q;
    rdy_o  = busy ? (rdy_i & last_o) : 1'b1;
  end

  // Vector, mask and zero-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q   <= '0;
      mask_q  <= '0;
      zflag_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      zflag_q <= zflag_d;
    end
  end

  // Datapath next state: load on acceptance, retire lowest lane per beat.
  always_comb begin
    vec_d   = vec_q;
    mask_d  = mask_q;
    zflag_d = zflag_q;
    if (clear_i) begin
      vec_d   = '0;
      mask_d  = '0;
      zflag_d = 1'b0;
    end else if (in_acc) begin
      vec_d   = vec_i;
      mask_d  = mask_in;
      zflag_d = ~|mask_in;
    end else if (beat_acc) begin
      mask_d = mask_q & ~enc_onehot;
      if (last_o) begin
        vec_d   = '0;
        zflag_d = 1'b0;
      end
    end
  end

`ifdef ZS_COMPACTOR_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  logic [32:0] cnt_sum;

  // Saturating add of zero lanes in each accepted vector.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (33'(N) - 33'(zs_popcount(64'(mask_in))));
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (in_acc) begin
      cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  // Skip counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zskip_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_zs_compactor.sv
// Self-checking bench for zs_compactor: directed scenarios plus random
// traffic, all compared against a queue-of-beats reference model.
module tb_zs_compactor;
  import zs_pkg::*;

  localparam int unsigned N  = ZsN;
  localparam int unsigned DW = ZsDw;
  localparam int unsigned IW = $clog2(N);

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic [N*DW-1:0] vec_i;
  logic            vld_i;
  logic            rdy_o;
  logic [DW-1:0]   val_o;
  logic [IW-1:0]   idx_o;
  logic            last_o;
  logic            nz_o;
  logic            vld_o;
  logic            rdy_i;
`ifdef ZS_COMPACTOR_STATS_EN
  logic [31:0]     zskip_cnt_o;
`endif

  zs_compactor #(
    .N (N),
    .DW(DW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .vec_i      (vec_i),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .val_o      (val_o),
    .idx_o      (idx_o),
    .last_o     (last_o),
    .nz_o       (nz_o),
    .vld_o      (vld_o),
`ifdef ZS_COMPACTOR_STATS_EN
    .zskip_cnt_o(zskip_cnt_o),
`endif
    .rdy_i      (rdy_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: beats still owed for the vector in flight, and the
  // expected skip count.
  zs_beat_t    exp_q[$];
  longint      exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] mk_vec(input logic [DW-1:0] l [N]);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = l[k];
    return v;
  endfunction

  // Expand a vector into the beats it should produce, lane 0 first.
  task automatic push_vector(input logic [N*DW-1:0] v);
    zs_beat_t b;
    int       nzero = 0;
    for (int k = 0; k < N; k++) begin
      if (v[k*DW +: DW] != '0) begin
        b.val  = v[k*DW +: DW];
        b.idx  = IW'(k);
        b.last = 1'b0;
        b.nz   = 1'b1;
        exp_q.push_back(b);
        nzero++;
      end
    end
    if (nzero == 0) begin
      b = '{val: '0, idx: '0, last: 1'b1, nz: 1'b0};
      exp_q.push_back(b);
    end else begin
      exp_q[exp_q.size()-1].last = 1'b1;
    end
    exp_cnt = exp_cnt + (N - nzero);
    if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
  endtask

  // One clock: drive at negedge, check just after, then advance the model.
  task automatic cycle(input logic [N*DW-1:0] v, input logic vl, input logic rd,
                       input logic cl);
    logic     exp_rdy;
    zs_beat_t obs;
    @(negedge clk_i);
    vec_i   = v;
    vld_i   = vl;
    rdy_i   = rd;
    clear_i = cl;
    #1;
    exp_rdy = (exp_q.size() == 0) ? 1'b1 : (rd && exp_q.size() == 1);
    check("rdy_o", 64'(rdy_o), 64'(exp_rdy));
    check("vld_o", 64'(vld_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      obs = '{val: val_o, idx: idx_o, last: last_o, nz: nz_o};
      check("beat", 64'(obs), 64'(exp_q[0]));
    end
`ifdef ZS_COMPACTOR_STATS_EN
    check("zskip_cnt", 64'(zskip_cnt_o), 64'(exp_cnt));
`endif
    if (cl) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (exp_q.size() != 0 && rd) void'(exp_q.pop_front());
      if (vl && exp_rdy) push_vector(v);
    end
  endtask

  task automatic idle_cycles(input int n, input logic rd);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, rd, 1'b0);
  endtask

  logic [DW-1:0]   lanes [N];
  logic [N*DW-1:0] v1, vzero, va, vb, vr;

  initial begin
    lanes = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd3};
    v1    = mk_vec(lanes);
    vzero = '0;
    for (int k = 0; k < N; k++) va[k*DW +: DW] = 8'h11;
    vb = '0;
    vb[7*DW +: DW] = 8'h22;

    rst_ni  = 1'b0;
    clear_i = 1'b0;
    vec_i   = '0;
    vld_i   = 1'b0;
    rdy_i   = 1'b0;
    #12;
    check("rst_vld_o", 64'(vld_o), 64'(0));
    check("rst_rdy_o", 64'(rdy_o), 64'(1));
    check("rst_last_o", 64'(last_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Sparse vector, full throughput.
    cycle(v1, 1'b1, 1'b1, 1'b0);
    idle_cycles(4, 1'b1);

    // All-zero vector marker beat.
    cycle(vzero, 1'b1, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // Back-to-back: dense then single-lane vector with no bubble.
    cycle(va, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(vb, 1'b1, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // Backpressure pattern on the sparse vector.
    cycle(v1, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // Clear after the first beat, then a fresh vector.
    cycle(v1, 1'b1, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(v1, 1'b1, 1'b1, 1'b1);
    cycle(v1, 1'b1, 1'b1, 1'b0);
    idle_cycles(4, 1'b1);

    // Async reset while stalled in BUSY.
    cycle(v1, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_vld_o", 64'(vld_o), 64'(0));
    check("arst_rdy_o", 64'(rdy_o), 64'(1));
`ifdef ZS_COMPACTOR_STATS_EN
    check("arst_zskip_cnt", 64'(zskip_cnt_o), 64'(0));
`endif
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_cycles(2, 1'b1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        vr[k*DW +: DW] = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
      end
      if ($urandom_range(0, 9) == 0) vr = '0;
      cycle(vr, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0);
    end
    idle_cycles(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
